// File: rtl/nios_pio_pkg.sv
// Shared register offsets, edge/irq mode encodings and the write-data width mask
// for the Nios II PIO slave.
package nios_pio_pkg;
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    function automatic logic [31:0] mask_wd(input logic [31:0] wd, input int width);
        return (width >= 32) ? wd : (wd & ((32'd1 << width) - 32'd1));
    endfunction
endpackage

// File: rtl/nios_pio_sync.sv
// Per-bit reset-to-zero synchroniser chain for asynchronous pin inputs.
// Latency SYNC_STAGES cycles; no flow control.
module nios_pio_sync #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/nios_pio_ctrl.sv
// Avalon-MM PIO slave: data/dir/mask/edge registers, atomic set/clear, sticky edge capture, irq.
// Zero-wait-state combinational reads; writes land at the next clk edge; irq is registered.
module nios_pio_ctrl
    import nios_pio_pkg::*;
#(
    parameter int          WIDTH       = 10,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter logic [31:0] DIR_RESET   = 32'd0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          IRQ_TYPE    = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);
    localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

    // Registers are held 32 bits wide; everything written is masked so bits >= WIDTH stay 0.
    logic [31:0]      data_out, dir, irq_mask, edge_cap, in_prev;
    logic [31:0]      wd, in_sync32, evt, edge_clr;
    logic [WIDTH-1:0] in_sync;
    logic [2:0]       prime_cnt;
    logic             wr, primed;

    nios_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (in_sync)
    );

    assign wr        = chipselect & ~write_n;
    assign wd        = mask_wd(writedata, WIDTH);
    assign in_sync32 = 32'(in_sync);
    assign primed    = (prime_cnt == PRIME_MAX);
    assign edge_clr  = (wr && address == ADDR_EDGE) ? wd : 32'd0;

    always_comb begin
        evt = 32'd0;
        case (EDGE_TYPE)
            EDGE_RISE: evt = in_sync32 & ~in_prev;
            EDGE_FALL: evt = ~in_sync32 & in_prev;
            default:   evt = in_sync32 ^ in_prev;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= mask_wd(RESET_VALUE, WIDTH);
            dir       <= mask_wd(DIR_RESET, WIDTH);
            irq_mask  <= 32'd0;
            edge_cap  <= 32'd0;
            in_prev   <= 32'd0;
            prime_cnt <= 3'd0;
            irq       <= 1'b0;
        end else begin
            in_prev <= in_sync32;
            if (!primed) prime_cnt <= prime_cnt + 3'd1;
            // A new event in the same cycle as a clear keeps the bit set.
            edge_cap <= (edge_cap & ~edge_clr) | (primed ? evt : 32'd0);
            irq      <= |(((IRQ_TYPE == IRQ_LEVEL) ? in_sync32 : edge_cap) & irq_mask);
            if (wr) begin
                case (address)
                    ADDR_DATA:   data_out <= wd;
                    ADDR_DIR:    dir      <= wd;
                    ADDR_MASK:   irq_mask <= wd;
                    ADDR_OUTSET: data_out <= data_out | wd;
                    ADDR_OUTCLR: data_out <= data_out & ~wd;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA: readdata = (dir & data_out) | (~dir & in_sync32);
            ADDR_DIR:  readdata = dir;
            ADDR_MASK: readdata = irq_mask;
            ADDR_EDGE: readdata = edge_cap;
            default:   readdata = 32'd0;
        endcase
    end

    assign out_port = data_out[WIDTH-1:0];
    assign oe       = dir[WIDTH-1:0];
endmodule
